// File: rtl/sar_cmp_responder.sv
// Behavioural stand-in for a SAR front end: tracks and holds vin, answers DAC
// codes with a LAT-cycle comparator pipeline, and grades the final conversion.
module sar_cmp_responder #(
    parameter int NOB = 7,
    parameter int LAT = 1,
    parameter int CW  = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NOB-1:0] vin,
    input  logic           sample,
    input  logic [NOB-1:0] value,
    input  logic           valid,
    input  logic [NOB-1:0] result,
    output logic [1:0]     cmp,
    output logic [NOB-1:0] held,
    output logic           busy,
    output logic           match,
    output logic           mismatch,
    output logic [CW-1:0]  ncmp
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_TRACK = 2'd1,
        S_HOLD  = 2'd2,
        S_CHECK = 2'd3
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [NOB-1:0] r_held;
    logic           r_busy;
    logic           r_match;
    logic           r_mismatch;
    logic [CW-1:0]  r_ncmp;
    logic [1:0]     w_code;
    logic           w_shift;
    logic           w_ncmp_max;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (sample) w_next = S_TRACK;
            S_TRACK: if (!sample) w_next = S_HOLD;
            // valid has priority over an abort request in the same cycle
            S_HOLD: begin
                if (valid)       w_next = S_CHECK;
                else if (sample) w_next = S_TRACK;
            end
            S_CHECK: w_next = sample ? S_TRACK : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_code = 2'b11;
        if (r_held > value)      w_code = 2'b10;
        else if (r_held < value) w_code = 2'b01;
    end

    // The pipeline only advances while staying in HOLD; any other cycle flushes it,
    // so cmp reads 00 outside HOLD and for the first LAT cycles of each hold.
    assign w_shift    = (r_state == S_HOLD) && (w_next == S_HOLD);
    assign w_ncmp_max = (r_ncmp == {CW{1'b1}});

    genvar gi;
    generate
        for (gi = 0; gi < LAT; gi++) begin : g_pipe
            logic [1:0] r_stage;
            if (gi == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (rst || !w_shift) r_stage <= 2'b00;
                    else                 r_stage <= w_code;
                end
            end else begin : g_rest
                always_ff @(posedge clk) begin
                    if (rst || !w_shift) r_stage <= 2'b00;
                    else                 r_stage <= g_pipe[gi-1].r_stage;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_held     <= '0;
            r_busy     <= 1'b0;
            r_match    <= 1'b0;
            r_mismatch <= 1'b0;
            r_ncmp     <= '0;
        end else begin
            r_state    <= w_next;
            r_busy     <= (w_next == S_TRACK) || (w_next == S_HOLD);
            r_match    <= (r_state == S_HOLD) && valid && (result == r_held);
            r_mismatch <= (r_state == S_HOLD) && valid && (result != r_held);
            if ((r_state == S_TRACK) && sample)
                r_held <= vin;
            case (r_state)
                S_TRACK: r_ncmp <= '0;
                S_HOLD: begin
                    if (w_next == S_TRACK)
                        r_ncmp <= '0;
                    else if (!w_ncmp_max)
                        r_ncmp <= r_ncmp + CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign cmp      = g_pipe[LAT-1].r_stage;
    assign held     = r_held;
    assign busy     = r_busy;
    assign match    = r_match;
    assign mismatch = r_mismatch;
    assign ncmp     = r_ncmp;

endmodule

// File: doc/sar_cmp_responder.md
Name: sar_cmp_responder

Overview:
- Digital stand-in for the analog front end of the binary-search SAR converter: sample-and-hold, DAC and comparator.
- Responds to the SAR FSM's `sample` and `value` outputs by driving the 2-bit `cmp` code.
- When the FSM asserts `valid`, checks the FSM's `result` against the held input and pulses a pass/fail flag.
- Used in-chip for SAR self-test and as the bench model for converter verification.

Parameters:
- NOB, 7: converter resolution in bits; width of `vin`, `value` and `result`.
- LAT, 1: comparator latency in clock cycles, from `value` change to `cmp` update; legal range 1..8.
- CW, 4: width of the comparison counter `ncmp`.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- vin  input  NOB  digital "analog" input code to be converted.
- sample  input  1  from the SAR FSM; high = track `vin`, falling edge = hold.
- value  input  NOB  DAC code from the SAR FSM.
- valid  input  1  end-of-conversion strobe from the SAR FSM.
- result  input  NOB  conversion result from the SAR FSM; read only when `valid` = 1.
- cmp  output  2  comparator code to the SAR FSM.
- held  output  NOB  currently held sample.
- busy  output  1  high in TRACK or HOLD.
- match  output  1  one-cycle pulse: `result` == `held`.
- mismatch  output  1  one-cycle pulse: `result` != `held`.
- ncmp  output  CW  comparisons counted since hold began; saturating.

Behaviour:
Reset (synchronous, `rst` = 1 at a rising edge):
- state = IDLE.
- held, cmp, ncmp, match, mismatch, busy and every pipeline stage = 0.
- Reset wins over all other inputs in the same cycle.

States and transitions:
- IDLE:
  - `sample` = 1 -> TRACK.
  - `valid` is ignored.
- TRACK:
  - `held` <= `vin` every cycle while `sample` = 1.
  - `sample` = 0 -> HOLD; `held` keeps the value captured on the last cycle `sample` was high.
  - `ncmp` <= 0.
- HOLD:
  - Each cycle, stage 0 computes a code from `held` vs `value`:
    - 2'b10 when held > value (SAR keeps the bit).
    - 2'b01 when held < value (SAR clears the bit).
    - 2'b11 when equal.
  - The code passes through LAT registers and appears on `cmp` LAT cycles after `value` is presented.
  - `ncmp` increments once per HOLD cycle and saturates at 2^CW-1.
  - `valid` = 1 -> CHECK. `result` is sampled in this cycle.
  - `sample` = 1 with `valid` = 0 -> TRACK (abort); pipeline flushed, `ncmp` cleared.
  - `valid` and `sample` both high -> CHECK; `sample` is re-evaluated in CHECK.
- CHECK (exactly 1 cycle):
  - Exactly one of `match` / `mismatch` is high, from the comparison latched in HOLD.
  - Next state: TRACK if `sample` = 1, else IDLE.

Output rules:
- `cmp` = 2'b00 whenever state != HOLD. On HOLD entry the pipeline is flushed, so the first valid code appears at HOLD cycle LAT.
- `busy` = 1 in TRACK or HOLD; 0 in IDLE and CHECK.
- `held` is stable outside TRACK.
- All comparisons are unsigned NOB-bit. No arithmetic wrap: `value` and `vin` are used as-is.

Test Plan:
1. NOB=7, LAT=1: `vin`=85, `sample` high 3 cycles then low, `value`=64 -> `cmp`=2'b10 one cycle later. `value`=96 -> 2'b01. `value`=85 -> 2'b11. `held`=85 throughout.
2. After scenario 1, `valid`=1 with `result`=85 -> `match`=1 for exactly one cycle, `mismatch`=0, `busy`=0, state IDLE. Repeat with `result`=84 -> `mismatch` pulse only.
3. LAT=3, `vin`=10, hold, step `value` 0 -> 20 -> `cmp` changes 2'b10 -> 2'b01 exactly 3 cycles after the step. `cmp`=2'b00 for the first 3 HOLD cycles.
4. `rst`=1 in the middle of HOLD with `ncmp`=5 -> next cycle: all outputs 0, state IDLE. A following `valid` pulse produces no `match` or `mismatch`.
5. CW=4, HOLD held for 20 cycles -> `ncmp` saturates at 15. Re-assert `sample` (abort) -> `ncmp`=0, `cmp`=2'b00, state TRACK.
6. Connected to the 7-bit SAR FSM, sweep `vin` over 0, 1, 63, 64, 126, 127 -> `match` pulses for every conversion, never `mismatch`. `ncmp` >= 7 at each `valid`.
